// File: rtl/lut_layer_pkg.sv
// Shared types and elaboration-time helpers for the streamed-table LUT layer.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Never returns less than 1 so counters stay at least one bit wide.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(v)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int slice_off(input int k, input int a);
    return k * a;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron's truth table: synchronous write, registered read that doubles
// as the layer's output pipeline register.
module lut_neuron_ram #(
  parameter int OUT_BW = 2,
  parameter int A      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [A-1:0]      waddr,
  input  logic [OUT_BW-1:0] wdata,
  input  logic              re,
  input  logic [A-1:0]      raddr,
  output logic [OUT_BW-1:0] rdata
);

  (* rom_style = "distributed" *) logic [OUT_BW-1:0] mem [2**A];

  // Table contents are deliberately not reset; the FSM guards against stale use.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_layer_stream.sv
// Layer of N_NEURONS LUT neurons with tables streamed in over a config port
// and valid/ready handshakes on input and output.
module lut_layer_stream
  import lut_layer_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int FAN_IN    = 3,
  parameter int IN_BW     = 2,
  parameter int OUT_BW    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_NEURONS*FAN_IN*IN_BW-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_NEURONS*OUT_BW-1:0] out_data,
  input  logic                        cfg_start,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [OUT_BW-1:0]           cfg_data,
  output logic                        cfg_done,
  output logic                        loaded
);

  localparam int A  = FAN_IN * IN_BW;
  localparam int D  = 1 << A;
  localparam int W  = N_NEURONS * D;
  localparam int CW = clog2(W);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            cfg_fire;
  logic            last_word;
  logic [N_NEURONS-1:0] we;

  assign accept    = in_valid & in_ready;
  // A word presented together with cfg_start is dropped: the restart wins.
  assign cfg_fire  = cfg_valid & cfg_ready & ~cfg_start;
  assign last_word = (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    loaded    = 1'b0;
    case (state)
      EMPTY: begin
        if (cfg_start) state_nxt = LOAD;
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_fire && last_word) state_nxt = RUN;
      end
      RUN: begin
        loaded   = 1'b1;
        in_ready = ~out_valid | out_ready;
        if (cfg_start) state_nxt = LOAD;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                              cnt <= '0;
    else if (state != LOAD || cfg_start)  cnt <= '0;
    else if (cfg_fire)                    cnt <= last_word ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_done <= 1'b0;
    else     cfg_done <= cfg_fire & last_word;
  end

  always_ff @(posedge clk) begin
    if (rst)            out_valid <= 1'b0;
    else if (accept)    out_valid <= 1'b1;
    else if (out_ready) out_valid <= 1'b0;
  end

  for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
    localparam int OFF = slice_off(k, A);

    // Upper counter bits select the neuron, lower bits the table entry.
    assign we[k] = cfg_fire && ((cnt >> A) == CW'(k));

    lut_neuron_ram #(
      .OUT_BW (OUT_BW),
      .A      (A)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we[k]),
      .waddr (cnt[A-1:0]),
      .wdata (cfg_data),
      .re    (accept),
      .raddr (in_data[OFF +: A]),
      .rdata (out_data[k*OUT_BW +: OUT_BW])
    );
  end

endmodule

// File: doc/lut_layer_stream.md
# lut_layer_stream

Parametrised, pipelined layer of LUT neurons with runtime-loadable truth tables. Each of N_NEURONS neurons maps a FAN_IN×IN_BW-bit input slice to an OUT_BW-bit output through a per-neuron table. Tables are streamed in over a config port instead of being hard-coded per neuron. The layer sits between ensemble layers in the jet-substructure datapath and carries valid/ready handshakes on both sides.

## Interface
Parameters:
- N_NEURONS, 8, neurons in the layer
- FAN_IN, 3, inputs per neuron
- IN_BW, 2, bits per neuron input
- OUT_BW, 2, bits per neuron output
- Derived (localparam): A = FAN_IN·IN_BW; D = 2^A entries per neuron; W = N_NEURONS·D total words; CW = clog2(W)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  layer accepts input
- in_data  in  N_NEURONS·A  neuron k address = in_data[k·A +: A]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_data  out  N_NEURONS·OUT_BW  neuron k result at [k·OUT_BW +: OUT_BW]
- cfg_start  in  1  begin or restart table load
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  load word accepted when cfg_valid & cfg_ready
- cfg_data  in  OUT_BW  table entry
- cfg_done  out  1  one-cycle pulse after the last word is written
- loaded  out  1  high in RUN

## Operation
- FSM states: EMPTY (reset, no valid tables), LOAD, RUN.
- EMPTY: in_ready=0, cfg_ready=0. cfg_start → LOAD.
- LOAD: cfg_ready=1, in_ready=0. Load counter cnt (CW bits) starts at 0.
  - Each accepted word writes table[cnt / D][cnt % D] = cfg_data, then cnt increments.
  - Fill order is neuron 0 entries 0..D-1, then neuron 1, and so on.
  - The word accepted at cnt = W-1 moves the FSM to RUN and drives cfg_done high for the next cycle only.
  - cfg_start in LOAD resets cnt to 0 and stays in LOAD; a word accepted in the same cycle is discarded.
- RUN: in_ready = !out_valid | out_ready. Accept when in_valid & in_ready.
  - Every neuron reads its table at its slice address in parallel; results are registered into out_data and out_valid is set.
  - out_valid clears when out_ready is high and no new input is accepted.
  - cfg_start → LOAD.
- Simultaneous cfg_start and input accept in RUN: the input is accepted and looked up with the old tables, and the FSM enters LOAD next cycle.
- A pending out_valid/out_data survives entry into LOAD and is held until out_ready. Table rewrites never alter a registered output.
- Table contents are not reset. rst returns the FSM to EMPTY, so stale tables cannot be used until a full reload completes.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, cfg_ready=0, cfg_done=0, loaded=0, cnt=0, state EMPTY.
- Inference latency is 1 cycle: input accepted at edge t gives out_valid=1 with data after edge t. Throughput is 1 word/cycle when out_ready is held high.
- Load takes W cycles at full cfg_valid rate.
  - The transition to RUN and the cfg_done pulse occur on the edge that accepts word W-1.
  - in_ready may rise in the cycle immediately after that edge.
- No combinational path from in_valid to in_ready. in_ready depends only on state, out_valid and out_ready.
- rst mid-load or mid-stream: all outputs take reset values on the next edge, and any in-flight output is dropped.

## Structure
- Package lut_layer_pkg holds:
  - a typedef enum for states {EMPTY, LOAD, RUN}
  - a clog2 function
  - a helper for the slice offset k·A
- Sub-module lut_neuron_ram(OUT_BW, A), instantiated N_NEURONS times. It has one synchronous write port and one synchronous read port with a registered read (rom_style distributed). Its read register forms the out_data pipeline stage, with the output enable gated by the accept condition.
- Top level holds the FSM, the load counter and its decode to write-enable and address, and the handshake logic.

## Test plan
Default parameters (D=64, W=512) for all scenarios.
- Reset then in_valid=1 for 20 cycles → in_ready=0, out_valid=0 throughout, loaded=0.
- Load table[k][a] = (a + k) mod 4, then stream all 64 addresses to every neuron → out_data neuron k = (a + k) mod 4 for each input, 1-cycle latency, cfg_done high for exactly 1 cycle after word 511.
- Load, then hold out_ready=0 with in_valid=1 → one word captured, in_ready=0 and out_data stable; release out_ready → back-to-back output, 1 word/cycle.
- Load, send input a=5 to all neurons, then assert cfg_start in the same cycle → output uses the old tables; the FSM is in LOAD next cycle and in_ready=0 until the new 512 words complete.
- Mid-load at word 200:
  - assert cfg_start → the next accepted word writes table[0][0], and 512 further words are required for cfg_done;
  - assert rst instead → EMPTY, loaded=0, cfg_ready=0.
- Random in_valid/out_ready backpressure over 10k inputs against a reference model → no drops, no duplicates, correct order.
